// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the oversampled receiver (and the future
// transmitter):
//   - uart_state_e  : frame state encoding
//   - MAJ_OFS_*     : majority-vote sample offsets relative to Oversampling/2
//   - maj3()        : 2-of-3 majority function
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    // Samples are taken at Oversampling/2 + offset; the bit is decided on the
    // late sample, so the late offset also marks the decision tick.
    localparam int MAJ_OFS_EARLY = -1;
    localparam int MAJ_OFS_MID   = 0;
    localparam int MAJ_OFS_LATE  = 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Input conditioning for the UART receiver: two-flop synchronizer on the raw
// serial line, falling-edge detector and 3-sample majority voter.
//
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   i_rxd        : raw asynchronous serial line (idle high)
//   i_sample     : capture the current synced level as a vote sample
//   o_rxd_sync   : synchronized serial line
//   o_fall       : synced line went 1 -> 0 on the last clk
//   o_majority   : 2-of-3 vote of the two stored samples and the current level
// -----------------------------------------------------------------------------
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_rxd,
    input  logic i_sample,
    output logic o_rxd_sync,
    output logic o_fall,
    output logic o_majority
);

    logic [1:0] r_sync;     // [0] metastability catcher, [1] synced level
    logic       r_prev;     // synced level one clk earlier, for edge detection
    logic [1:0] r_samples;  // early and mid vote samples

    // All flops reset to the idle (high) level so releasing reset never
    // fabricates a start edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= 2'b11;
            r_prev    <= 1'b1;
            r_samples <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rxd};
            r_prev <= r_sync[1];
            if (i_sample) begin
                r_samples <= {r_samples[0], r_sync[1]};
            end
        end
    end

    assign o_rxd_sync = r_sync[1];
    assign o_fall     = r_prev & ~r_sync[1];
    // The third vote is the live synced level, so the decision is available
    // on the same tick as the late sample.
    assign o_majority = maj3(r_samples[1], r_samples[0], r_sync[1]);

endmodule

// File: rtl/uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampled
// Oversampled UART receiver: start + DataBits (LSB first) + stop, each bit
// lasting Oversampling ticks, bit value taken as a 2-of-3 majority around the
// bit centre. A low stop bit reports a frame error and parks the receiver in
// BREAK until the line returns high.
//
// Optional feature (compile-time macro UART_RX_PARITY_EN): one even-parity
// bit between data and stop, reported on parity_error.
//
// Parameters:
//   Oversampling : ticks per bit period (8..64)
//   DataBits     : payload width (5..8)
// Ports:
//   clk          : system clock, all state on rising edge
//   rst_n        : asynchronous active-low reset
//   tick         : one-clk strobe at Baud*Oversampling
//   rxd          : asynchronous serial line, idle high
//   data         : last good received word
//   data_valid   : one-clk pulse, data updated
//   frame_error  : one-clk pulse, stop bit sampled low
//   parity_error : one-clk pulse, parity mismatch (UART_RX_PARITY_EN only)
//   busy         : high in every state except IDLE
//   baud_en      : enable for the upstream tick generator
// -----------------------------------------------------------------------------
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int Oversampling = 16,
    parameter int DataBits     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                rxd,
    output logic [DataBits-1:0] data,
    output logic                data_valid,
    output logic                frame_error,
`ifdef UART_RX_PARITY_EN
    output logic                parity_error,
`endif
    output logic                busy,
    output logic                baud_en
);

    localparam int CNT_W = $clog2(Oversampling);
    localparam int BIT_W = $clog2(DataBits);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Oversampling - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(Oversampling / 2 + MAJ_OFS_EARLY);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(Oversampling / 2 + MAJ_OFS_MID);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(Oversampling / 2 + MAJ_OFS_LATE);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DataBits - 1);

    uart_state_e         r_state;
    logic [CNT_W-1:0]    r_tick_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [DataBits-1:0] r_shift;
    logic [DataBits-1:0] r_data;
    logic                r_data_valid;
    logic                r_frame_error;
    logic                r_busy;
`ifdef UART_RX_PARITY_EN
    logic                r_parity_bad;
    logic                r_parity_error;
`endif

    logic w_rxd_sync;
    logic w_fall;
    logic w_majority;
    logic w_sample;
    logic w_decide;
    logic w_wrap;
    logic w_start_edge;

    assign w_sample = tick && (r_tick_cnt == CNT_S0 || r_tick_cnt == CNT_S1);
    assign w_decide = tick && (r_tick_cnt == CNT_DEC);
    assign w_wrap   = tick && (r_tick_cnt == CNT_LAST);

    uart_rx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rxd      (rxd),
        .i_sample   (w_sample),
        .o_rxd_sync (w_rxd_sync),
        .o_fall     (w_fall),
        .o_majority (w_majority)
    );

    // Start detection needs no tick; it only applies in IDLE, so edges seen
    // while in BREAK are consumed by the edge detector and ignored.
    assign w_start_edge = (r_state == ST_IDLE) && w_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_tick_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_data         <= '0;
            r_data_valid   <= 1'b0;
            r_frame_error  <= 1'b0;
            r_busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_bad   <= 1'b0;
            r_parity_error <= 1'b0;
`endif
        end else begin
            // Pulses default low so each lasts exactly one clk.
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_error <= 1'b0;
`endif

            // Bit timing runs only in the bit-timed states; IDLE and BREAK
            // keep the counter parked at zero.
            if (tick && r_state != ST_IDLE && r_state != ST_BREAK) begin
                r_tick_cnt <= (r_tick_cnt == CNT_LAST) ? '0 : r_tick_cnt + CNT_W'(1);
            end

            // NOTE: the case has a default arm and every register keeps its
            // value unless assigned, so no unintended hold logic is inferred.
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state    <= ST_START;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_busy     <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_decide && w_majority) begin
                        // Line back high at mid start bit: a glitch.
                        r_state    <= ST_IDLE;
                        r_tick_cnt <= '0;
                        r_busy     <= 1'b0;
                    end else if (w_wrap) begin
                        r_state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_decide) begin
                        // LSB arrives first: shift in at the top, move right.
                        r_shift <= {w_majority, r_shift[DataBits-1:1]};
                    end
                    if (w_wrap) begin
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state   <= ST_PARITY;
`else
                            r_state   <= ST_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_decide) begin
                        // Even parity: data ones plus parity bit must be even.
                        r_parity_bad <= ^{r_shift, w_majority};
                    end
                    if (w_wrap) begin
                        r_state <= ST_STOP;
                    end
                end
`endif

                ST_STOP: begin
                    if (w_decide) begin
                        r_tick_cnt <= '0;
                        if (w_majority) begin
                            // Leave half a bit early so a following start edge
                            // is caught with no idle gap.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (r_parity_bad) begin
                                r_parity_error <= 1'b1;
                            end else begin
                                r_data       <= r_shift;
                                r_data_valid <= 1'b1;
                            end
`else
                            r_data       <= r_shift;
                            r_data_valid <= 1'b1;
`endif
                        end else begin
                            r_state       <= ST_BREAK;
                            r_frame_error <= 1'b1;
                        end
                    end
                end

                ST_BREAK: begin
                    if (tick && w_rxd_sync) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data        = r_data;
    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_error;
    assign busy        = r_busy;
    // The start-edge term enables the tick generator on the very clk the edge
    // is seen, before busy has registered.
    assign baud_en     = r_busy | w_start_edge;
`ifdef UART_RX_PARITY_EN
    assign parity_error = r_parity_error;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversampled
// Self-checking bench for uart_rx_oversampled (Oversampling=16, DataBits=8,
// tick every 4th clk). Frames are described at the word level; the expected
// outcome of each frame (good word, frame error, parity error) is queued and
// matched against the DUT pulses by a per-cycle compare process that also
// tracks the expected value of data. Parity cases build with UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b0;
    logic       rxd   = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;
    logic       busy;
    logic       baud_en;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`else
    logic       parity_error = 1'b0;
`endif

    uart_rx_oversampled #(.Oversampling(OS), .DataBits(DB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .rxd          (rxd),
        .data         (data),
        .data_valid   (data_valid),
        .frame_error  (frame_error),
`ifdef UART_RX_PARITY_EN
        .parity_error (parity_error),
`endif
        .busy         (busy),
        .baud_en      (baud_en)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    // ---------------- model: queue of expected frame outcomes ----------------
    typedef enum int {EV_DATA = 1, EV_FERR = 2, EV_PERR = 3} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] value;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        cur_ev;
    logic [7:0] model_data = 8'h00;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_dv = 0, n_fe = 0, n_pe = 0;
    logic       prev_dv = 1'b0, prev_fe = 1'b0, prev_pe = 1'b0;
    int         act_kind;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_data(input logic [7:0] v);
        ev_t e;
        e.kind  = EV_DATA;
        e.value = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_event(input ev_kind_e k);
        ev_t e;
        e.kind  = k;
        e.value = 8'h00;
        exp_q.push_back(e);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            model_data = 8'h00;
            check("reset_data", {24'd0, data}, 32'h0);
            check("reset_pulses", {29'd0, data_valid, frame_error, parity_error}, 32'h0);
            check("reset_busy_baud_en", {30'd0, busy, baud_en}, 32'h0);
        end else begin
            if (data_valid || frame_error || parity_error) begin
                check("pulse_exclusive", 32'($countones({data_valid, frame_error, parity_error})), 32'd1);
                act_kind = data_valid ? int'(EV_DATA) : frame_error ? int'(EV_FERR) : int'(EV_PERR);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got kind %0d, required no pulse (t=%0t)", act_kind, $time);
                end else begin
                    cur_ev = exp_q.pop_front();
                    check("pulse_kind", act_kind, int'(cur_ev.kind));
                    if (cur_ev.kind == EV_DATA) model_data = cur_ev.value;
                end
            end
            if (data_valid) begin
                n_dv++;
                check("dv_one_clk", {31'd0, prev_dv}, 32'h0);
            end
            if (frame_error) begin
                n_fe++;
                check("fe_one_clk", {31'd0, prev_fe}, 32'h0);
            end
            if (parity_error) begin
                n_pe++;
                check("pe_one_clk", {31'd0, prev_pe}, 32'h0);
            end
            check("data_value", {24'd0, data}, {24'd0, model_data});
            check("baud_en_when_busy", {31'd0, baud_en | ~busy}, 32'h1);
        end
        prev_dv = data_valid & rst_n;
        prev_fe = frame_error & rst_n;
        prev_pe = parity_error & rst_n;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic b, input int clks);
        rxd = b;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stop_val, input int stop_clks);
        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < DB; i++) drive(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        drive(par, BIT_CLKS);
`else
        if (par === 1'bx) $display("note: parity argument undefined");
`endif
        drive(stop_val, stop_clks);
    endtask

    initial begin
        // Watchdog: all stimulus is fixed-length, this only guards a stall.
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, BIT_CLKS);

        // Frame 0xA5, checking that busy drops before the stop bit ends.
        expect_data(8'hA5);
        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive(1'(8'hA5 >> i), BIT_CLKS);
        check("a5_busy_mid_frame", {31'd0, busy}, 32'h1);
        for (int i = 4; i < 8; i++) drive(1'(8'hA5 >> i), BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        drive(even_par(8'hA5), BIT_CLKS);
`endif
        drive(1'b1, BIT_CLKS * 3 / 4);
        check("a5_busy_low_mid_stop", {31'd0, busy}, 32'h0);
        check("a5_data", {24'd0, data}, 32'hA5);
        check("a5_dv_count", n_dv, 1);
        drive(1'b1, BIT_CLKS - BIT_CLKS * 3 / 4);

        // Glitch: low for 5 ticks then high.
        drive(1'b0, 12);
        check("glitch_busy_started", {31'd0, busy}, 32'h1);
        drive(1'b0, 5 * TICK_DIV - 12);
        drive(1'b1, 2 * BIT_CLKS);
        check("glitch_busy_low", {31'd0, busy}, 32'h0);
        check("glitch_data_kept", {24'd0, data}, 32'hA5);
        check("glitch_no_pulse", n_dv + n_fe, 1);

        // 0x3C with stop low, line held low 30 bit times, then 0x55.
        expect_event(EV_FERR);
        send_frame(8'h3C, even_par(8'h3C), 1'b0, 30 * BIT_CLKS);
        check("break_busy", {30'd0, busy, baud_en}, 32'h3);
        check("break_fe_count", n_fe, 1);
        check("break_data_kept", {24'd0, data}, 32'hA5);
        drive(1'b1, BIT_CLKS);
        check("break_exit_idle", {31'd0, busy}, 32'h0);
        expect_data(8'h55);
        send_frame(8'h55, even_par(8'h55), 1'b1, BIT_CLKS);
        check("after_break_data", {24'd0, data}, 32'h55);
        check("after_break_fe_count", n_fe, 1);

        // Back-to-back 0x00 then 0xFF with no idle gap.
        expect_data(8'h00);
        expect_data(8'hFF);
        send_frame(8'h00, even_par(8'h00), 1'b1, BIT_CLKS);
        send_frame(8'hFF, even_par(8'hFF), 1'b1, BIT_CLKS);
        check("b2b_data", {24'd0, data}, 32'hFF);
        check("b2b_dv_count", n_dv, 4);

        // Reset during bit 4 of 0x81, then 0x7E.
        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive(1'(8'h81 >> i), BIT_CLKS);
        drive(1'b0, BIT_CLKS / 2);
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mid_reset_data", {24'd0, data}, 32'h0);
        rst_n = 1'b1;
        drive(1'b1, 2 * BIT_CLKS);
        check("post_reset_idle", {31'd0, busy}, 32'h0);
        expect_data(8'h7E);
        send_frame(8'h7E, even_par(8'h7E), 1'b1, BIT_CLKS);
        check("post_reset_data", {24'd0, data}, 32'h7E);
        check("post_reset_dv_count", n_dv, 5);

`ifdef UART_RX_PARITY_EN
        // 0x01 with wrong then right parity bit.
        expect_event(EV_PERR);
        send_frame(8'h01, 1'b0, 1'b1, BIT_CLKS);
        check("parity_bad_data_kept", {24'd0, data}, 32'h7E);
        check("parity_bad_pe_count", n_pe, 1);
        expect_data(8'h01);
        send_frame(8'h01, 1'b1, 1'b1, BIT_CLKS);
        check("parity_good_data", {24'd0, data}, 32'h01);
        check("parity_good_dv_count", n_dv, 6);
`endif

        drive(1'b1, 2 * BIT_CLKS);
        check("outcomes_drained", exp_q.size(), 0);
        check("final_fe_count", n_fe, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
